datamem_arbiter: RTL and testbench

- Shares the single-ported word data memory between two requesters: master 0 (CPU load/store unit) and master 1 (debug/DMA loader).
- Memory model: combinational read, write on posedge clk when we=1, word index = address[6:2].
- Arbiter grants one access per cycle using round-robin and returns a registered response one cycle later.
- Rejects out-of-range and misaligned addresses without touching memory.

---
 rtl/datamem_arbiter_pkg.sv | 15 +
 rtl/datamem_arbiter_if.sv | 16 +
 rtl/datamem_arbiter_rr_arb2.sv | 30 +++
 rtl/datamem_arbiter.sv | 78 +++++++
 tb/tb_datamem_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/datamem_arbiter_pkg.sv
// Shared constants and request bundle for the two-master data memory arbiter.
package dmem_pkg;
    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    localparam int unsigned DMEM_WIDTH   = 32;
    localparam int unsigned DMEM_IDX_LSB = 2;
    localparam int unsigned DMEM_IDX_MSB = 6;

    typedef struct packed {
        logic                  we;
        logic [DMEM_WIDTH-1:0] addr;
        logic [DMEM_WIDTH-1:0] wdata;
    } dmem_req_t;
endpackage

// File: rtl/datamem_arbiter_if.sv
// Per-master request/grant/response bundle; master drives the request, slave answers.
interface datamem_arbiter_if #(
    parameter int WIDTH = dmem_pkg::DMEM_WIDTH
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             err;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/datamem_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational; last_gnt register moves on every granted edge.
// No backpressure of its own: an ungranted requester simply holds until selected.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On contention the master that did not win last time goes next.
            2'b11:   gnt = (last_gnt == 1'(M1)) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'(M1);
        else if (|gnt)
            last_gnt <= gnt[M1];
    end
endmodule

// File: rtl/datamem_arbiter.sv
// Shares a single-ported word memory between two masters; one access per cycle, response 1 cycle after gnt.
// Ungranted master sees gnt=0 and holds its request; bad addresses answer err without touching memory.
module datamem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH   = DMEM_WIDTH,
    parameter int IDX_LSB = DMEM_IDX_LSB,
    parameter int IDX_MSB = DMEM_IDX_MSB
) (
    input  logic             clk,
    input  logic             rst_n,
    datamem_arbiter_if.slave m0,
    datamem_arbiter_if.slave m1,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_datain,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_dataout
);
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             granted;
    logic             err_now;
    dmem_req_t        sel;
    logic [1:0]       rvalid_q;
    logic [1:0]       err_q;
    logic [WIDTH-1:0] rdata_q [2];

    assign req = {m1.req, m0.req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign m0.gnt  = gnt[M0];
    assign m1.gnt  = gnt[M1];
    assign granted = |gnt;

    // With no grant the selected bundle is all zero, which also parks the memory bus at 0.
    always_comb begin
        sel = '0;
        if (gnt[M0])
            sel = '{we: m0.we, addr: m0.addr, wdata: m0.wdata};
        else if (gnt[M1])
            sel = '{we: m1.we, addr: m1.addr, wdata: m1.wdata};
    end

    assign err_now = (sel.addr[WIDTH-1:IDX_MSB+1] != '0) ||
                     (sel.addr[IDX_LSB-1:0] != '0);

    assign mem_address = sel.addr;
    assign mem_datain  = sel.wdata;
    assign mem_we      = granted & sel.we & ~err_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= gnt[i];
                err_q[i]    <= gnt[i] & err_now;
                rdata_q[i]  <= (gnt[i] & ~sel.we & ~err_now) ? mem_dataout : '0;
            end
        end
    end

    assign m0.rvalid = rvalid_q[M0];
    assign m0.err    = err_q[M0];
    assign m0.rdata  = rdata_q[M0];
    assign m1.rvalid = rvalid_q[M1];
    assign m1.err    = err_q[M1];
    assign m1.rdata  = rdata_q[M1];
endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;
    logic        clk;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;
    logic [31:0] mem [32];
    logic        mem_ready;
    int          checks;
    int          errors;

    datamem_arbiter_if #(.WIDTH(32)) mi0 ();
    datamem_arbiter_if #(.WIDTH(32)) mi1 ();

    datamem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (mi0),
        .m1          (mi1),
        .mem_address (mem_address),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_address[6:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= (i == 20) ? 32'h0000_00A3 : 32'h0;
        end else if (mem_we) begin
            mem[mem_address[6:2]] <= mem_datain;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mi0.req = r; mi0.we = w; mi0.addr = a; mi0.wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mi1.req = r; mi1.we = w; mi1.addr = a; mi1.wdata = d;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic at_pos();
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) at_pos();

        // reset state
        check("rst_m0_rvalid", {31'b0, mi0.rvalid}, 32'h0);
        check("rst_m1_rvalid", {31'b0, mi1.rvalid}, 32'h0);
        check("rst_m0_rdata",  mi0.rdata, 32'h0);
        check("rst_m1_rdata",  mi1.rdata, 32'h0);
        check("rst_errs",      {30'b0, mi1.err, mi0.err}, 32'h0);

        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;

        // continuous contention from reset: m0, m1, m0, m1
        set_m0(1'b1, 1'b0, 32'h50, 32'h0);
        set_m1(1'b1, 1'b0, 32'h54, 32'h0);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) at_neg();
            check("cont_gnt", {30'b0, mi1.gnt, mi0.gnt}, (c % 2 == 0) ? 32'h1 : 32'h2);
            at_pos();
            check("cont_rvalid", {30'b0, mi1.rvalid, mi0.rvalid}, (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c == 0) check("cont_m0_rdata", mi0.rdata, 32'h0000_00A3);
        end
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);

        // m0 alone loads preloaded word 0x14
        at_neg();
        set_m0(1'b1, 1'b0, 32'h50, 32'h0);
        #1;
        check("ld_m0_gnt", {30'b0, mi1.gnt, mi0.gnt}, 32'h1);
        check("ld_mem_we", {31'b0, mem_we}, 32'h0);
        at_pos();
        check("ld_m0_rvalid", {31'b0, mi0.rvalid}, 32'h1);
        check("ld_m0_rdata",  mi0.rdata, 32'h0000_00A3);
        check("ld_m0_err",    {31'b0, mi0.err}, 32'h0);
        check("ld_m1_rvalid", {31'b0, mi1.rvalid}, 32'h0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);

        // m1 store then m0 load of the same word
        at_neg();
        set_m1(1'b1, 1'b1, 32'h60, 32'h258);
        #1;
        check("st_m1_gnt",  {30'b0, mi1.gnt, mi0.gnt}, 32'h2);
        check("st_mem_we",  {31'b0, mem_we}, 32'h1);
        check("st_mem_adr", mem_address, 32'h60);
        check("st_mem_din", mem_datain, 32'h258);
        at_pos();
        check("st_m1_rvalid", {31'b0, mi1.rvalid}, 32'h1);
        check("st_m1_rdata",  mi1.rdata, 32'h0);
        @(negedge clk);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        set_m0(1'b1, 1'b0, 32'h60, 32'h0);
        #1;
        check("rdw_m0_gnt", {30'b0, mi1.gnt, mi0.gnt}, 32'h1);
        at_pos();
        check("rdw_m0_rdata", mi0.rdata, 32'h0000_0258);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);

        // out-of-range store (m0) and misaligned load (m1); last winner was m0
        at_neg();
        set_m0(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF);
        set_m1(1'b1, 1'b0, 32'h52, 32'h0);
        #1;
        check("bad_gnt_a",  {30'b0, mi1.gnt, mi0.gnt}, 32'h2);
        check("bad_we_a",   {31'b0, mem_we}, 32'h0);
        at_pos();
        check("bad_m1_resp", {30'b0, mi1.err, mi1.rvalid}, 32'h3);
        check("bad_m1_rdata", mi1.rdata, 32'h0);
        @(negedge clk);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("bad_gnt_b",  {30'b0, mi1.gnt, mi0.gnt}, 32'h1);
        check("bad_we_b",   {31'b0, mem_we}, 32'h0);
        at_pos();
        check("bad_m0_resp", {30'b0, mi0.err, mi0.rvalid}, 32'h3);
        check("bad_m0_rdata", mi0.rdata, 32'h0);
        check("bad_mem0",     mem[0], 32'h0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);

        // reset pulse while a response is live; m0 must win after release
        at_neg();
        set_m0(1'b1, 1'b0, 32'h50, 32'h0);
        set_m1(1'b1, 1'b1, 32'h54, 32'h0);
        #1;
        check("rp_gnt_pre", {30'b0, mi1.gnt, mi0.gnt}, 32'h2);
        at_pos();
        check("rp_rvalid_pre", {31'b0, mi1.rvalid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rp_rvalid_async", {30'b0, mi1.rvalid, mi0.rvalid}, 32'h0);
        check("rp_err_async",    {30'b0, mi1.err, mi0.err}, 32'h0);
        #1 rst_n = 1'b1;
        at_neg();
        check("rp_gnt_post", {30'b0, mi1.gnt, mi0.gnt}, 32'h1);
        at_pos();
        check("rp_m0_rdata", mi0.rdata, 32'h0000_00A3);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);

        // m1 streams three loads with m0 silent
        at_neg();
        set_m1(1'b1, 1'b0, 32'h60, 32'h0);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) at_neg();
            check("bb_m1_gnt", {30'b0, mi1.gnt, mi0.gnt}, 32'h2);
            at_pos();
            check("bb_m1_rvalid", {31'b0, mi1.rvalid}, 32'h1);
            check("bb_m1_rdata",  mi1.rdata, 32'h0000_0258);
        end
        @(negedge clk);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        at_pos();
        check("idle_rvalid", {30'b0, mi1.rvalid, mi0.rvalid}, 32'h0);
        check("idle_rdata",  mi1.rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
